// File: rtl/sd_spi_engine_if.sv
// Command / read-back bus between the $C1Exxx read-to-trigger decoder and
// the SD SPI shift engine.
//   master : decoder side (drives CMD_*, HIGH_SPEED; reads status and RX data)
//   slave  : engine side
interface sd_spi_engine_if;
    logic        CMD_VALID;
    logic [1:0]  CMD_OP;
    logic [7:0]  CMD_DATA;
    logic        HIGH_SPEED;
    logic        BUSY;
    logic [7:0]  RX_BYTE;
    logic [15:0] RX_WORD;
    logic        RX_VALID;
    logic [7:0]  BURST_LEFT;
    logic [15:0] RX_CRC;

    modport master (
        output CMD_VALID, CMD_OP, CMD_DATA, HIGH_SPEED,
        input  BUSY, RX_BYTE, RX_WORD, RX_VALID, BURST_LEFT, RX_CRC
    );

    modport slave (
        input  CMD_VALID, CMD_OP, CMD_DATA, HIGH_SPEED,
        output BUSY, RX_BYTE, RX_WORD, RX_VALID, BURST_LEFT, RX_CRC
    );
endinterface

// File: rtl/sd_spi_engine.sv
// SPI mode-0 shift engine for the cartridge SD port. Executes one-cycle
// decoder commands as byte (SEND) or word (BURST/NEXT) transfers, MSB first,
// and publishes received data atomically in the DONE cycle.
// Ports:
//   CLOCK_50 / nRESET      : clock, asynchronous active-low reset
//   bus (slave modport)    : command strobe/opcode/data, HIGH_SPEED, status,
//                            RX_BYTE/RX_WORD/RX_VALID, BURST_LEFT, RX_CRC
//   SPI_CLK/SPI_MOSI       : SD_CLK / SD_CMD (registered)
//   SPI_MISO               : SD_DAT
// Optional feature macro: SD_SPI_CRC16_EN (CRC16-CCITT over burst data;
// when undefined RX_CRC is tied to zero).
module sd_spi_engine #(
    parameter int unsigned SLOW_DIV = 30,
    parameter int unsigned FAST_DIV = 0
) (
    input  logic           CLOCK_50,
    input  logic           nRESET,
    sd_spi_engine_if.slave bus,
    output logic           SPI_CLK,
    output logic           SPI_MOSI,
    input  logic           SPI_MISO
);
    localparam int unsigned DIV_W  = 8;
    localparam int unsigned BIT_W  = 5;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned BYTE_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] OP_SEND  = 2'b00;
    localparam logic [1:0] OP_NEXT  = 2'b01;
    localparam logic [1:0] OP_BURST = 2'b10;
    localparam logic [1:0] OP_ABORT = 2'b11;

    logic [1:0]        r_state, w_state;
    logic [DIV_W-1:0]  r_div, w_div;
    logic [DIV_W-1:0]  r_cnt, w_cnt;
    logic [BIT_W-1:0]  r_bits, w_bits;
    logic              r_word, w_word;
    logic              r_clk, w_clk;
    logic              r_busy, w_busy;
    logic              r_rx_valid, w_rx_valid;
    logic [WORD_W-1:0] r_tx, w_tx;
    logic [WORD_W-1:0] r_sr, w_sr;
    logic [WORD_W-1:0] r_rx_word, w_rx_word;
    logic [BYTE_W-1:0] r_rx_byte, w_rx_byte;
    logic [BYTE_W-1:0] r_burst_left, w_burst_left;
    logic              w_cnt_done;
    logic              w_start;
    logic              w_start_word;
    logic [BYTE_W-1:0] w_start_tx;

`ifdef SD_SPI_CRC16_EN
    logic [WORD_W-1:0] r_crc, w_crc;

    // CRC16-CCITT (poly 0x1021), one byte MSB first
    function automatic logic [WORD_W-1:0] crc16_byte(input logic [WORD_W-1:0] crc,
                                                     input logic [BYTE_W-1:0] data);
        logic [WORD_W-1:0] c;
        c = crc;
        for (int i = BYTE_W - 1; i >= 0; i--) begin
            c = {c[WORD_W-2:0], 1'b0} ^ ((c[WORD_W-1] ^ data[i]) ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction
`endif

    // Next-state and next-output logic
    always_comb begin
        w_state      = r_state;
        w_div        = r_div;
        w_cnt        = r_cnt;
        w_bits       = r_bits;
        w_word       = r_word;
        w_clk        = r_clk;
        w_busy       = r_busy;
        w_rx_valid   = 1'b0;
        w_tx         = r_tx;
        w_sr         = r_sr;
        w_rx_word    = r_rx_word;
        w_rx_byte    = r_rx_byte;
        w_burst_left = r_burst_left;
        w_start      = 1'b0;
        w_start_word = 1'b0;
        w_start_tx   = 8'hFF;
        w_cnt_done   = (r_cnt == r_div);
`ifdef SD_SPI_CRC16_EN
        w_crc        = r_crc;
`endif

        case (r_state)
            ST_IDLE: begin
                if (bus.CMD_VALID) begin
                    case (bus.CMD_OP)
                        OP_SEND: begin
                            w_start    = 1'b1;
                            w_start_tx = bus.CMD_DATA;
                        end
                        OP_BURST: begin
                            w_start      = 1'b1;
                            w_start_word = 1'b1;
                            w_burst_left = bus.CMD_DATA;
                        end
                        OP_NEXT: begin
                            if (r_burst_left != '0) begin
                                w_start      = 1'b1;
                                w_start_word = 1'b1;
                                w_burst_left = r_burst_left - BYTE_W'(1);
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_LOW: begin
                w_cnt = r_cnt + DIV_W'(1);
                if (w_cnt_done) begin
                    // rising SCK: sample MISO on the same edge the clock goes high
                    w_cnt   = '0;
                    w_state = ST_HIGH;
                    w_clk   = 1'b1;
                    w_sr    = {r_sr[WORD_W-2:0], SPI_MISO};
                    w_bits  = r_bits - BIT_W'(1);
                end
            end
            ST_HIGH: begin
                w_cnt = r_cnt + DIV_W'(1);
                if (w_cnt_done) begin
                    w_cnt = '0;
                    w_clk = 1'b0;
                    if (r_bits == '0) begin
                        w_state    = ST_DONE;
                        w_tx       = '1;
                        w_rx_valid = 1'b1;
                        w_rx_byte  = r_sr[BYTE_W-1:0];
                        w_rx_word  = r_word ? r_sr : {r_rx_word[BYTE_W-1:0], r_sr[BYTE_W-1:0]};
`ifdef SD_SPI_CRC16_EN
                        if (r_word) begin
                            w_crc = crc16_byte(crc16_byte(r_crc, r_sr[WORD_W-1:BYTE_W]),
                                               r_sr[BYTE_W-1:0]);
                        end
`endif
                    end else begin
                        // falling SCK: next bit onto MOSI, refill with 1
                        w_state = ST_LOW;
                        w_tx    = {r_tx[WORD_W-2:0], 1'b1};
                    end
                end
            end
            ST_DONE: begin
                w_state = ST_IDLE;
                w_busy  = 1'b0;
            end
            default: w_state = ST_IDLE;
        endcase

        // Common transfer launch; DIV is frozen here for the whole transfer
        if (w_start) begin
            w_state = ST_LOW;
            w_busy  = 1'b1;
            w_cnt   = '0;
            w_clk   = 1'b0;
            w_word  = w_start_word;
            w_bits  = w_start_word ? BIT_W'(16) : BIT_W'(8);
            w_div   = bus.HIGH_SPEED ? DIV_W'(FAST_DIV) : DIV_W'(SLOW_DIV);
            w_tx    = {w_start_tx, 8'hFF};
`ifdef SD_SPI_CRC16_EN
            if (bus.CMD_OP == OP_BURST) begin
                w_crc = '0;
            end
`endif
        end

        // ABORT wins from any state and never publishes partial data
        if (bus.CMD_VALID && (bus.CMD_OP == OP_ABORT)) begin
            w_state      = ST_IDLE;
            w_busy       = 1'b0;
            w_cnt        = '0;
            w_clk        = 1'b0;
            w_tx         = '1;
            w_burst_left = '0;
            w_rx_valid   = 1'b0;
            w_rx_byte    = r_rx_byte;
            w_rx_word    = r_rx_word;
`ifdef SD_SPI_CRC16_EN
            w_crc        = '0;
`endif
        end
    end

    // State and output registers
    always_ff @(posedge CLOCK_50 or negedge nRESET) begin
        if (!nRESET) begin
            r_state      <= ST_IDLE;
            r_div        <= '0;
            r_cnt        <= '0;
            r_bits       <= '0;
            r_word       <= 1'b0;
            r_clk        <= 1'b0;
            r_busy       <= 1'b0;
            r_rx_valid   <= 1'b0;
            r_tx         <= '1;
            r_sr         <= '0;
            r_rx_word    <= '0;
            r_rx_byte    <= '0;
            r_burst_left <= '0;
`ifdef SD_SPI_CRC16_EN
            r_crc        <= '0;
`endif
        end else begin
            r_state      <= w_state;
            r_div        <= w_div;
            r_cnt        <= w_cnt;
            r_bits       <= w_bits;
            r_word       <= w_word;
            r_clk        <= w_clk;
            r_busy       <= w_busy;
            r_rx_valid   <= w_rx_valid;
            r_tx         <= w_tx;
            r_sr         <= w_sr;
            r_rx_word    <= w_rx_word;
            r_rx_byte    <= w_rx_byte;
            r_burst_left <= w_burst_left;
`ifdef SD_SPI_CRC16_EN
            r_crc        <= w_crc;
`endif
        end
    end

    assign SPI_CLK        = r_clk;
    assign SPI_MOSI       = r_tx[WORD_W-1];
    assign bus.BUSY       = r_busy;
    assign bus.RX_VALID   = r_rx_valid;
    assign bus.RX_BYTE    = r_rx_byte;
    assign bus.RX_WORD    = r_rx_word;
    assign bus.BURST_LEFT = r_burst_left;
`ifdef SD_SPI_CRC16_EN
    assign bus.RX_CRC     = r_crc;
`else
    assign bus.RX_CRC     = 16'h0000;
`endif
endmodule

// File: tb/tb_sd_spi_engine.sv
// Bench for sd_spi_engine: scenario tasks driving decoder commands, with
// expected RX events queued at command time and matched as RX_VALID fires.
module tb_sd_spi_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic spi_clk, spi_mosi, spi_miso;
    logic echo, miso_drv;

    sd_spi_engine_if bus();

    assign spi_miso = echo ? spi_mosi : miso_drv;

    sd_spi_engine #(.SLOW_DIV(30), .FAST_DIV(0)) dut (
        .CLOCK_50 (clk),
        .nRESET   (rst_n),
        .bus      (bus),
        .SPI_CLK  (spi_clk),
        .SPI_MOSI (spi_mosi),
        .SPI_MISO (spi_miso)
    );

    localparam logic [1:0] OP_SEND  = 2'b00;
    localparam logic [1:0] OP_NEXT  = 2'b01;
    localparam logic [1:0] OP_BURST = 2'b10;
    localparam logic [1:0] OP_ABORT = 2'b11;

    int checks = 0;
    int failures = 0;

    logic [15:0] exp_word_q[$];
    logic [7:0]  exp_byte_q[$];
    logic [15:0] obs_word_q[$];
    logic [7:0]  obs_byte_q[$];

    // reference model state
    logic [15:0] m_word, m_crc;
    logic [7:0]  m_byte, m_left;

    // observation results
    int          busy_n, valid_n, nbits, hi_len, lo_len;
    logic [15:0] mosi_bits;
    logic        first_mosi, tmo;
    logic [15:0] ew, ow;
    logic [7:0]  eb, ob;

    // bit-serial CRC16-CCITT over a 16-bit word, MSB first
    function automatic logic [15:0] crc_word(input logic [15:0] c, input logic [15:0] w);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 15; i >= 0; i--) begin
            fb = r[15] ^ w[i];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h1021;
        end
        return r;
    endfunction

    function automatic logic [15:0] exp_crc(input logic [15:0] c);
`ifdef SD_SPI_CRC16_EN
        return c;
`else
        return (c & 16'h0000);
`endif
    endfunction

    task automatic push_exp(input logic [15:0] w, input logic [7:0] b);
        exp_word_q.push_back(w);
        exp_byte_q.push_back(b);
    endtask

    // one-cycle command strobe; returns at the negedge of the first busy cycle
    task automatic do_cmd(input logic [1:0] op, input logic [7:0] d, input logic hs);
        bus.CMD_VALID  = 1'b1;
        bus.CMD_OP     = op;
        bus.CMD_DATA   = d;
        bus.HIGH_SPEED = hs;
        @(negedge clk);
        bus.CMD_VALID  = 1'b0;
    endtask

    // follows a transfer until BUSY drops; pattern mode drives MISO from pat
    task automatic observe(input int max_cyc, input int mode, input logic [15:0] pat,
                           input int inj_k, input logic [1:0] inj_op, input logic [7:0] inj_d);
        logic prev_clk;
        logic ended;
        busy_n = 0; valid_n = 0; nbits = 0; hi_len = 0; lo_len = 0;
        mosi_bits = '0; first_mosi = spi_mosi; prev_clk = 1'b0; ended = 1'b0;
        for (int k = 0; k < max_cyc; k++) begin
            bus.CMD_VALID = 1'b0;
            if (!bus.BUSY) begin
                ended = 1'b1;
                break;
            end
            if (k == inj_k) begin
                bus.CMD_VALID = 1'b1;
                bus.CMD_OP    = inj_op;
                bus.CMD_DATA  = inj_d;
            end
            busy_n++;
            if (bus.RX_VALID) begin
                valid_n++;
                obs_word_q.push_back(bus.RX_WORD);
                obs_byte_q.push_back(bus.RX_BYTE);
            end
            if (spi_clk && !prev_clk) begin
                mosi_bits = {mosi_bits[14:0], spi_mosi};
                nbits++;
            end
            if (!spi_clk && nbits == 0) lo_len++;
            if (spi_clk && nbits == 1) hi_len++;
            if (mode == 2 && !spi_clk && nbits < 16) miso_drv = pat[15 - nbits];
            prev_clk = spi_clk;
            @(negedge clk);
        end
        tmo = !ended;
    endtask

    task automatic test_reset;
        checks++;
        if ({spi_clk, spi_mosi, bus.BUSY, bus.RX_VALID} !== 4'b0100) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0100", {spi_clk, spi_mosi, bus.BUSY, bus.RX_VALID});
        end
        checks++;
        if ({bus.RX_BYTE, bus.RX_WORD, bus.BURST_LEFT, bus.RX_CRC} !== 48'h0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", {bus.RX_BYTE, bus.RX_WORD, bus.BURST_LEFT, bus.RX_CRC});
        end
    endtask

    task automatic test_fast_send;
        echo = 1'b1;
        m_word = {m_word[7:0], 8'hA5}; m_byte = 8'hA5;
        push_exp(m_word, m_byte);
        do_cmd(OP_SEND, 8'hA5, 1'b1);
        observe(200, 0, 16'h0, -1, OP_SEND, 8'h00);
        checks++; if (tmo) begin failures++; $display("FAIL send_timeout got=1 exp=0"); end
        checks++; if (busy_n !== 17) begin failures++; $display("FAIL send_busy got=%0d exp=17", busy_n); end
        checks++; if (valid_n !== 1) begin failures++; $display("FAIL send_valid got=%0d exp=1", valid_n); end
        checks++; if (first_mosi !== 1'b1) begin failures++; $display("FAIL send_first_mosi got=%b exp=1", first_mosi); end
        checks++;
        if (nbits !== 8 || mosi_bits[7:0] !== 8'hA5) begin
            failures++; $display("FAIL send_mosi got=%0d/%h exp=8/a5", nbits, mosi_bits[7:0]);
        end
        while (exp_word_q.size() != 0) begin
            ew = exp_word_q.pop_front(); eb = exp_byte_q.pop_front(); checks++;
            if (obs_word_q.size() == 0) begin failures++; $display("FAIL send_sb got=none exp=%h/%h", ew, eb); end
            else begin
                ow = obs_word_q.pop_front(); ob = obs_byte_q.pop_front();
                if (ow !== ew || ob !== eb) begin failures++; $display("FAIL send_sb got=%h/%h exp=%h/%h", ow, ob, ew, eb); end
            end
        end
        checks++;
        if (obs_word_q.size() != 0) begin
            failures++; $display("FAIL send_extra_rx got=%0d exp=0", obs_word_q.size());
            obs_word_q.delete(); obs_byte_q.delete();
        end
    endtask

    task automatic test_slow_word;
        echo = 1'b0;
        m_word = 16'h1234; m_byte = 8'h34; m_left = 8'd1;
        m_crc = crc_word(16'h0, m_word);
        push_exp(m_word, m_byte);
        do_cmd(OP_BURST, 8'd1, 1'b0);
        bus.HIGH_SPEED = 1'b1;  // must not affect the running transfer
        observe(2000, 2, 16'h1234, -1, OP_SEND, 8'h00);
        checks++; if (tmo) begin failures++; $display("FAIL slow_timeout got=1 exp=0"); end
        checks++; if (busy_n !== 993) begin failures++; $display("FAIL slow_busy got=%0d exp=993", busy_n); end
        checks++;
        if (lo_len !== 31 || hi_len !== 31) begin
            failures++; $display("FAIL slow_half_period got=%0d/%0d exp=31/31", lo_len, hi_len);
        end
        checks++;
        if (nbits !== 16 || mosi_bits !== 16'hFFFF) begin
            failures++; $display("FAIL slow_mosi got=%0d/%h exp=16/ffff", nbits, mosi_bits);
        end
        checks++; if (bus.BURST_LEFT !== m_left) begin failures++; $display("FAIL slow_left got=%0d exp=%0d", bus.BURST_LEFT, m_left); end
        checks++; if (bus.RX_CRC !== exp_crc(m_crc)) begin failures++; $display("FAIL slow_crc got=%h exp=%h", bus.RX_CRC, exp_crc(m_crc)); end
        m_word = 16'hBEEF; m_byte = 8'hEF; m_left = 8'd0;
        m_crc = crc_word(m_crc, m_word);
        push_exp(m_word, m_byte);
        do_cmd(OP_NEXT, 8'h00, 1'b1);
        observe(200, 2, 16'hBEEF, -1, OP_SEND, 8'h00);
        checks++; if (busy_n !== 33) begin failures++; $display("FAIL next_busy got=%0d exp=33", busy_n); end
        checks++; if (bus.BURST_LEFT !== m_left) begin failures++; $display("FAIL next_left got=%0d exp=0", bus.BURST_LEFT); end
        checks++; if (bus.RX_CRC !== exp_crc(m_crc)) begin failures++; $display("FAIL next_crc got=%h exp=%h", bus.RX_CRC, exp_crc(m_crc)); end
        while (exp_word_q.size() != 0) begin
            ew = exp_word_q.pop_front(); eb = exp_byte_q.pop_front(); checks++;
            if (obs_word_q.size() == 0) begin failures++; $display("FAIL slow_sb got=none exp=%h/%h", ew, eb); end
            else begin
                ow = obs_word_q.pop_front(); ob = obs_byte_q.pop_front();
                if (ow !== ew || ob !== eb) begin failures++; $display("FAIL slow_sb got=%h/%h exp=%h/%h", ow, ob, ew, eb); end
            end
        end
        checks++;
        if (obs_word_q.size() != 0) begin
            failures++; $display("FAIL slow_extra_rx got=%0d exp=0", obs_word_q.size());
            obs_word_q.delete(); obs_byte_q.delete();
        end
    endtask

    task automatic test_burst_full;
        int total;
        int bad;
        echo = 1'b0; miso_drv = 1'b1; total = 0;
        m_crc = 16'h0;
        for (int i = 0; i < 256; i++) begin
            m_word = 16'hFFFF; m_byte = 8'hFF;
            m_crc = crc_word(m_crc, m_word);
            push_exp(m_word, m_byte);
            if (i == 0) do_cmd(OP_BURST, 8'hFF, 1'b1);
            else        do_cmd(OP_NEXT, 8'h00, 1'b1);
            observe(200, 0, 16'h0, -1, OP_SEND, 8'h00);
            total += valid_n;
            checks++; if (tmo) begin failures++; $display("FAIL burst_timeout word=%0d got=1 exp=0", i); end
        end
        checks++; if (total !== 256) begin failures++; $display("FAIL burst_valid_count got=%0d exp=256", total); end
        checks++; if (bus.BURST_LEFT !== 8'd0) begin failures++; $display("FAIL burst_left got=%0d exp=0", bus.BURST_LEFT); end
        checks++; if (bus.RX_CRC !== exp_crc(m_crc)) begin failures++; $display("FAIL burst_crc got=%h exp=%h", bus.RX_CRC, exp_crc(m_crc)); end
        do_cmd(OP_NEXT, 8'h00, 1'b1);
        bad = 0;
        repeat (40) begin
            if (bus.BUSY || bus.RX_VALID) bad++;
            @(negedge clk);
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL burst_extra_next got=%0d exp=0", bad); end
        while (exp_word_q.size() != 0) begin
            ew = exp_word_q.pop_front(); eb = exp_byte_q.pop_front(); checks++;
            if (obs_word_q.size() == 0) begin failures++; $display("FAIL burst_sb got=none exp=%h/%h", ew, eb); end
            else begin
                ow = obs_word_q.pop_front(); ob = obs_byte_q.pop_front();
                if (ow !== ew || ob !== eb) begin failures++; $display("FAIL burst_sb got=%h/%h exp=%h/%h", ow, ob, ew, eb); end
            end
        end
        checks++;
        if (obs_word_q.size() != 0) begin
            failures++; $display("FAIL burst_extra_rx got=%0d exp=0", obs_word_q.size());
            obs_word_q.delete(); obs_byte_q.delete();
        end
    endtask

    task automatic test_drop_while_busy;
        int bad;
        echo = 1'b1;
        m_word = {m_word[7:0], 8'h3C}; m_byte = 8'h3C;
        push_exp(m_word, m_byte);
        do_cmd(OP_SEND, 8'h3C, 1'b1);
        observe(200, 0, 16'h0, 4, OP_SEND, 8'hFF);
        checks++; if (busy_n !== 17) begin failures++; $display("FAIL drop_busy got=%0d exp=17", busy_n); end
        checks++; if (valid_n !== 1) begin failures++; $display("FAIL drop_valid got=%0d exp=1", valid_n); end
        checks++;
        if (nbits !== 8 || mosi_bits[7:0] !== 8'h3C) begin
            failures++; $display("FAIL drop_mosi got=%0d/%h exp=8/3c", nbits, mosi_bits[7:0]);
        end
        bad = 0;
        repeat (30) begin
            if (bus.BUSY) bad++;
            @(negedge clk);
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL drop_queued got=%0d exp=0", bad); end
        while (exp_word_q.size() != 0) begin
            ew = exp_word_q.pop_front(); eb = exp_byte_q.pop_front(); checks++;
            if (obs_word_q.size() == 0) begin failures++; $display("FAIL drop_sb got=none exp=%h/%h", ew, eb); end
            else begin
                ow = obs_word_q.pop_front(); ob = obs_byte_q.pop_front();
                if (ow !== ew || ob !== eb) begin failures++; $display("FAIL drop_sb got=%h/%h exp=%h/%h", ow, ob, ew, eb); end
            end
        end
        checks++;
        if (obs_word_q.size() != 0) begin
            failures++; $display("FAIL drop_extra_rx got=%0d exp=0", obs_word_q.size());
            obs_word_q.delete(); obs_byte_q.delete();
        end
    endtask

    task automatic test_abort;
        int bad;
        echo = 1'b0;
        do_cmd(OP_BURST, 8'd5, 1'b1);
        // sample 6 is the LOW phase of bit 3 (fast: one cycle per phase)
        observe(200, 2, 16'h0F0F, 6, OP_ABORT, 8'h00);
        m_left = 8'd0; m_crc = 16'h0;
        checks++; if (tmo) begin failures++; $display("FAIL abort_timeout got=1 exp=0"); end
        checks++; if (busy_n !== 7) begin failures++; $display("FAIL abort_busy got=%0d exp=7", busy_n); end
        checks++;
        if ({spi_clk, spi_mosi} !== 2'b01) begin
            failures++; $display("FAIL abort_pins got=%b exp=01", {spi_clk, spi_mosi});
        end
        checks++; if (bus.BURST_LEFT !== 8'd0) begin failures++; $display("FAIL abort_left got=%0d exp=0", bus.BURST_LEFT); end
        checks++;
        if (bus.RX_WORD !== m_word || bus.RX_BYTE !== m_byte) begin
            failures++; $display("FAIL abort_rx got=%h/%h exp=%h/%h", bus.RX_WORD, bus.RX_BYTE, m_word, m_byte);
        end
        checks++; if (bus.RX_CRC !== 16'h0000) begin failures++; $display("FAIL abort_crc got=%h exp=0000", bus.RX_CRC); end
        bad = valid_n;
        repeat (40) begin
            if (bus.RX_VALID || spi_clk || bus.BUSY) bad++;
            @(negedge clk);
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL abort_quiet got=%0d exp=0", bad); end
        checks++;
        if (obs_word_q.size() != 0) begin
            failures++; $display("FAIL abort_extra_rx got=%0d exp=0", obs_word_q.size());
            obs_word_q.delete(); obs_byte_q.delete();
        end
    endtask

    task automatic test_back_to_back;
        echo = 1'b1;
        m_word = {m_word[7:0], 8'h81}; m_byte = 8'h81;
        push_exp(m_word, m_byte);
        do_cmd(OP_SEND, 8'h81, 1'b1);
        observe(200, 0, 16'h0, -1, OP_SEND, 8'h00);
        m_word = {m_word[7:0], 8'h42}; m_byte = 8'h42;
        push_exp(m_word, m_byte);
        do_cmd(OP_SEND, 8'h42, 1'b1);  // issued in the first cycle BUSY reads 0
        observe(200, 0, 16'h0, -1, OP_SEND, 8'h00);
        checks++; if (busy_n !== 17) begin failures++; $display("FAIL b2b_busy got=%0d exp=17", busy_n); end
        checks++;
        if (nbits !== 8 || mosi_bits[7:0] !== 8'h42) begin
            failures++; $display("FAIL b2b_mosi got=%0d/%h exp=8/42", nbits, mosi_bits[7:0]);
        end
        while (exp_word_q.size() != 0) begin
            ew = exp_word_q.pop_front(); eb = exp_byte_q.pop_front(); checks++;
            if (obs_word_q.size() == 0) begin failures++; $display("FAIL b2b_sb got=none exp=%h/%h", ew, eb); end
            else begin
                ow = obs_word_q.pop_front(); ob = obs_byte_q.pop_front();
                if (ow !== ew || ob !== eb) begin failures++; $display("FAIL b2b_sb got=%h/%h exp=%h/%h", ow, ob, ew, eb); end
            end
        end
        checks++;
        if (obs_word_q.size() != 0) begin
            failures++; $display("FAIL b2b_extra_rx got=%0d exp=0", obs_word_q.size());
            obs_word_q.delete(); obs_byte_q.delete();
        end
    endtask

    task automatic test_reset_mid;
        logic seen;
        echo = 1'b1; seen = 1'b0;
        do_cmd(OP_SEND, 8'h66, 1'b0);
        for (int i = 0; i < 200; i++) begin
            if (spi_clk) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++; if (!seen) begin failures++; $display("FAIL rstmid_no_sck got=0 exp=1"); end
        #2 rst_n = 1'b0;
        #1;
        m_word = 16'h0; m_byte = 8'h0; m_left = 8'h0; m_crc = 16'h0;
        checks++;
        if ({spi_clk, spi_mosi, bus.BUSY, bus.RX_VALID} !== 4'b0100) begin
            failures++; $display("FAIL rstmid_ctrl got=%b exp=0100", {spi_clk, spi_mosi, bus.BUSY, bus.RX_VALID});
        end
        checks++;
        if ({bus.RX_BYTE, bus.RX_WORD, bus.BURST_LEFT, bus.RX_CRC} !== 48'h0) begin
            failures++; $display("FAIL rstmid_data got=%h exp=0", {bus.RX_BYTE, bus.RX_WORD, bus.BURST_LEFT, bus.RX_CRC});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        m_word = {m_word[7:0], 8'h5A}; m_byte = 8'h5A;
        push_exp(m_word, m_byte);
        do_cmd(OP_SEND, 8'h5A, 1'b1);
        observe(200, 0, 16'h0, -1, OP_SEND, 8'h00);
        checks++; if (busy_n !== 17) begin failures++; $display("FAIL rstmid_busy got=%0d exp=17", busy_n); end
        checks++; if (valid_n !== 1) begin failures++; $display("FAIL rstmid_valid got=%0d exp=1", valid_n); end
        while (exp_word_q.size() != 0) begin
            ew = exp_word_q.pop_front(); eb = exp_byte_q.pop_front(); checks++;
            if (obs_word_q.size() == 0) begin failures++; $display("FAIL rstmid_sb got=none exp=%h/%h", ew, eb); end
            else begin
                ow = obs_word_q.pop_front(); ob = obs_byte_q.pop_front();
                if (ow !== ew || ob !== eb) begin failures++; $display("FAIL rstmid_sb got=%h/%h exp=%h/%h", ow, ob, ew, eb); end
            end
        end
        checks++;
        if (obs_word_q.size() != 0) begin
            failures++; $display("FAIL rstmid_extra_rx got=%0d exp=0", obs_word_q.size());
            obs_word_q.delete(); obs_byte_q.delete();
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        echo           = 1'b0;
        miso_drv       = 1'b1;
        bus.CMD_VALID  = 1'b0;
        bus.CMD_OP     = OP_SEND;
        bus.CMD_DATA   = 8'h00;
        bus.HIGH_SPEED = 1'b0;
        m_word = 16'h0; m_byte = 8'h0; m_left = 8'h0; m_crc = 16'h0;
        repeat (3) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        @(negedge clk);
        test_reset;
        test_fast_send;
        test_slow_word;
        test_burst_full;
        test_drop_while_busy;
        test_abort;
        test_back_to_back;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sd_spi_engine.md
# sd_spi_engine

SPI shift engine for the SD card port on the cartridge CPLD. Sits directly downstream of the 68K "read-to-trigger" address decoder, which turns nSYSROM_OE falling edges in the $C1Exxx window into one-cycle commands. The engine executes each command as SPI mode-0 byte or word transfers, with a hardware-sequenced 512-byte sector burst. It returns received data atomically, so the decoder's read-back mux never sees a half-shifted value.

## Interface
- SLOW_DIV, default 30: clock-divider terminal count in slow (init) mode; SPI half-period = SLOW_DIV+1 cycles.
- FAST_DIV, default 0: terminal count in high-speed mode.
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- nRESET  in  1  reset, asynchronous and active-low.
- CMD_VALID  in  1  one-cycle command strobe from the decoder.
- CMD_OP  in  2  opcode:
  - 00 SEND: transmit CMD_DATA.
  - 01 NEXT: continue the burst.
  - 10 BURST: start a burst; count = CMD_DATA.
  - 11 ABORT.
- CMD_DATA  in  8  TX byte for SEND; word count minus one for BURST.
- HIGH_SPEED  in  1  selects FAST_DIV (1) or SLOW_DIV (0); sampled at transfer start.
- BUSY  out  1  transfer in progress.
- RX_BYTE  out  8  last complete byte received.
- RX_WORD  out  16  last complete word; first received byte in [15:8].
- RX_VALID  out  1  one-cycle pulse when RX_BYTE/RX_WORD update.
- BURST_LEFT  out  8  words remaining after the current one.
- RX_CRC  out  16  running CRC16 of burst data (see Configuration).
- SPI_CLK  out  1  SD_CLK.
- SPI_MOSI  out  1  SD_CMD.
- SPI_MISO  in  1  SD_DAT.

## Operation
- States:
  - IDLE
  - LOW: SPI_CLK=0, MOSI holds the current bit.
  - HIGH: SPI_CLK=1.
  - DONE: single cycle; latches RX, pulses RX_VALID.
- In IDLE, CMD_VALID with:
  - SEND: 8-bit transfer, TX=CMD_DATA.
  - BURST: BURST_LEFT<=CMD_DATA; 16-bit transfer, TX=0xFF,0xFF; CRC cleared.
  - NEXT with BURST_LEFT!=0: BURST_LEFT decrements; 16-bit transfer of 0xFF.
  - NEXT with BURST_LEFT==0: ignored.
- Bit counter: 8 or 16 bits. MSB first. MOSI shifts left on the falling edge; the vacated bit is filled with 1.
- MISO is sampled on the cycle SPI_CLK rises (LOW->HIGH) into a 16-bit shift register.
- Each state holds DIV+1 cycles. DIV is latched from HIGH_SPEED at start; mid-transfer changes are ignored.
- After the last HIGH phase -> DONE:
  - RX_WORD <= shift register (16-bit transfer), or {RX_WORD[7:0], byte} (8-bit).
  - RX_BYTE <= last byte.
  - Then IDLE.
- Commands other than ABORT while BUSY are dropped.
- ABORT, any state: next cycle IDLE, SPI_CLK=0, MOSI=1, BURST_LEFT=0, RX outputs unchanged, no RX_VALID.
- Chip select stays in the decoder; the engine never touches CS.

## Timing
- Reset values:
  - SPI_CLK=0, SPI_MOSI=1, BUSY=0, RX_VALID=0.
  - RX_BYTE=0x00, RX_WORD=0x0000, BURST_LEFT=0, RX_CRC=0x0000, state IDLE.
- Async reset assert mid-transfer: all of the above immediately; SPI_CLK must not glitch high.
- CMD_VALID in cycle 0 -> BUSY=1 and first MOSI bit valid in cycle 1.
- BUSY stays high for 2*N*(DIV+1)+1 cycles (N = bits), DONE included. Fast byte: 17 cycles; slow word (30): 993 cycles.
- RX_VALID is high in the DONE cycle. BUSY falls the cycle after.
- A command arriving in the cycle BUSY reads 0 is accepted (back-to-back).
- SPI_CLK is a registered output, never combinational.

## Configuration
- SD_SPI_CRC16_EN defined: CRC16-CCITT (poly 0x1021, init 0x0000, MSB first) over every byte received in BURST/NEXT transfers.
  - Updates in the DONE cycle.
  - Cleared by BURST and by ABORT.
  - SEND bytes are excluded.
- Undefined: no CRC logic; RX_CRC tied to 0x0000.

## Test plan
- Fast SEND 0xA5, MISO echoes MOSI -> MOSI bits 1,0,1,0,0,1,0,1 on rising edges; BUSY 17 cycles; RX_BYTE=0xA5; RX_VALID one pulse.
- Slow NEXT/BURST, MISO = 0x12 then 0x34 -> RX_WORD=0x1234; SPI_CLK half-period exactly 31 cycles.
- BURST 0xFF then 255 NEXT, MISO held 1 -> 256 RX_VALID pulses; BURST_LEFT ends 0; extra NEXT ignored (BUSY stays 0); with SD_SPI_CRC16_EN, RX_CRC=0x7FA1.
- SEND while BUSY -> dropped; MOSI sequence unchanged; only one RX_VALID.
- ABORT during bit 3 of a word -> IDLE next cycle; SPI_CLK=0, MOSI=1, BURST_LEFT=0; RX_WORD unchanged; no RX_VALID.
- nRESET low mid-transfer -> all outputs at reset values asynchronously; first command after release behaves normally.
